// File: rtl/trig_seq_pkg.sv
// rtl/trig_seq_pkg.sv - shared constants and helpers for the trigger sequencer
// Purpose: FSM state encodings, edge-type encodings and stage-slice helpers
//          used by trig_seq and trig_stage_match.
// Ports:   none (package).
package trig_seq_pkg;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_RUN   = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Edge qualifier polarity
  localparam logic EDGE_RISING  = 1'b1;
  localparam logic EDGE_FALLING = 1'b0;

  // Width of one edge-channel index slice in cfg_edge_chan
  localparam int EDGE_CHAN_W = 8;

  // Low bit of stage `stage` inside a flattened per-stage config vector
  function automatic int stage_lo(input int stage, input int width);
    return stage * width;
  endfunction

endpackage

// File: rtl/trig_stage_match.sv
// rtl/trig_stage_match.sv - combinational match evaluator for one trigger stage
// Purpose: decides whether the current sample satisfies one stage condition
//          (masked pattern compare plus optional edge qualifier).
// Ports:
//   sample      in  SAMPLE_WIDTH  current sample
//   prev_sample in  SAMPLE_WIDTH  previous valid sample
//   pattern     in  SAMPLE_WIDTH  desired channel values
//   care        in  SAMPLE_WIDTH  1 = compare channel
//   edge_chan   in  8             channel index for the edge qualifier
//   edge_en     in  1             edge qualifier enable
//   edge_type   in  1             1 = rising, 0 = falling
//   match       out 1             stage condition holds
module trig_stage_match
  import trig_seq_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16
) (
  input  logic [SAMPLE_WIDTH-1:0] sample,
  input  logic [SAMPLE_WIDTH-1:0] prev_sample,
  input  logic [SAMPLE_WIDTH-1:0] pattern,
  input  logic [SAMPLE_WIDTH-1:0] care,
  input  logic [EDGE_CHAN_W-1:0]  edge_chan,
  input  logic                    edge_en,
  input  logic                    edge_type,
  output logic                    match
);

  logic cur_bit;
  logic prev_bit;
  logic chan_ok;
  logic edge_hit;
  logic pattern_ok;

  // Select the edge channel by comparison rather than by indexing so an
  // out-of-range channel simply leaves chan_ok low and the stage never matches.
  always_comb begin
    cur_bit  = 1'b0;
    prev_bit = 1'b0;
    chan_ok  = 1'b0;
    for (int i = 0; i < SAMPLE_WIDTH; i++) begin
      if (edge_chan == EDGE_CHAN_W'(i)) begin
        cur_bit  = sample[i];
        prev_bit = prev_sample[i];
        chan_ok  = 1'b1;
      end
    end
  end

  always_comb begin
    pattern_ok = (((sample ^ pattern) & care) == '0);
    if (edge_type == EDGE_RISING) begin
      edge_hit = chan_ok && !prev_bit && cur_bit;
    end else begin
      edge_hit = chan_ok && prev_bit && !cur_bit;
    end
    match = pattern_ok && (!edge_en || edge_hit);
  end

endmodule

// File: rtl/trig_seq.sv
// rtl/trig_seq.sv - multi-stage trigger sequencer for the logic capture path
// Purpose: steps through up to NUM_STAGES ordered trigger conditions on the
//          synchronised sample stream and fires a final trigger when the last
//          configured stage is satisfied. Configuration is shadowed on arm.
// Optional: define TRIG_SEQ_TIMEOUT_EN to add cfg_timeout and restart the
//           sequence after cfg_timeout valid samples spent in stages >= 1.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   arm, abort            start/restart and cancel pulses (abort wins)
//   sample_valid/_data    sample stream
//   cfg_*                 per-stage configuration, sampled on arm
//   cfg_timeout           (TRIG_SEQ_TIMEOUT_EN only) restart timeout
//   busy                  high in ARMED or RUN
//   trig_pulse            one-cycle final trigger
//   trig_latched          sticky trigger until arm/abort/reset
//   cur_stage             active stage index
//   match_count           matches accumulated in the active stage
module trig_seq
  import trig_seq_pkg::*;
#(
  parameter int SAMPLE_WIDTH = 16,
  parameter int NUM_STAGES   = 4,
  parameter int COUNT_WIDTH  = 16,
  localparam int STAGE_W     = $clog2(NUM_STAGES)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                arm,
  input  logic                                abort,
  input  logic                                sample_valid,
  input  logic [SAMPLE_WIDTH-1:0]             sample_data,
  input  logic [NUM_STAGES*SAMPLE_WIDTH-1:0]  cfg_pattern,
  input  logic [NUM_STAGES*SAMPLE_WIDTH-1:0]  cfg_care,
  input  logic [NUM_STAGES*EDGE_CHAN_W-1:0]   cfg_edge_chan,
  input  logic [NUM_STAGES-1:0]               cfg_edge_en,
  input  logic [NUM_STAGES-1:0]               cfg_edge_type,
  input  logic [NUM_STAGES*COUNT_WIDTH-1:0]   cfg_count,
  input  logic [STAGE_W-1:0]                  cfg_last_stage,
`ifdef TRIG_SEQ_TIMEOUT_EN
  input  logic [COUNT_WIDTH-1:0]              cfg_timeout,
`endif
  output logic                                busy,
  output logic                                trig_pulse,
  output logic                                trig_latched,
  output logic [STAGE_W-1:0]                  cur_stage,
  output logic [COUNT_WIDTH-1:0]              match_count
);

  // Shadow configuration
  logic [NUM_STAGES*SAMPLE_WIDTH-1:0] pattern_q, pattern_d;
  logic [NUM_STAGES*SAMPLE_WIDTH-1:0] care_q, care_d;
  logic [NUM_STAGES*EDGE_CHAN_W-1:0]  edge_chan_q, edge_chan_d;
  logic [NUM_STAGES-1:0]              edge_en_q, edge_en_d;
  logic [NUM_STAGES-1:0]              edge_type_q, edge_type_d;
  logic [NUM_STAGES*COUNT_WIDTH-1:0]  count_q, count_d;
  logic [STAGE_W-1:0]                 last_stage_q, last_stage_d;

  // Sequencer state
  logic [1:0]              state_q, state_d;
  logic [STAGE_W-1:0]      cur_stage_q, cur_stage_d;
  logic [COUNT_WIDTH-1:0]  match_count_q, match_count_d;
  logic [SAMPLE_WIDTH-1:0] prev_sample_q, prev_sample_d;
  logic                    trig_pulse_q, trig_pulse_d;
  logic                    trig_latched_q, trig_latched_d;

`ifdef TRIG_SEQ_TIMEOUT_EN
  logic [COUNT_WIDTH-1:0]  timeout_q, timeout_d;
  logic [COUNT_WIDTH-1:0]  timeout_cnt_q, timeout_cnt_d;
  logic [COUNT_WIDTH-1:0]  timeout_inc;
`endif

  // Active-stage configuration selected by cur_stage
  logic [SAMPLE_WIDTH-1:0] sel_pattern;
  logic [SAMPLE_WIDTH-1:0] sel_care;
  logic [EDGE_CHAN_W-1:0]  sel_edge_chan;
  logic                    sel_edge_en;
  logic                    sel_edge_type;
  logic [COUNT_WIDTH-1:0]  sel_count;
  logic [COUNT_WIDTH-1:0]  sel_target;
  logic                    stage_match;
  logic [COUNT_WIDTH-1:0]  count_inc;
  logic                    stage_done;

  logic load_cfg;
  assign load_cfg = arm && !abort;

  always_comb begin
    pattern_d    = pattern_q;
    care_d       = care_q;
    edge_chan_d  = edge_chan_q;
    edge_en_d    = edge_en_q;
    edge_type_d  = edge_type_q;
    count_d      = count_q;
    last_stage_d = last_stage_q;
    if (load_cfg) begin
      pattern_d   = cfg_pattern;
      care_d      = cfg_care;
      edge_chan_d = cfg_edge_chan;
      edge_en_d   = cfg_edge_en;
      edge_type_d = cfg_edge_type;
      count_d     = cfg_count;
      // Only reachable when NUM_STAGES is not a power of two
      if (int'(cfg_last_stage) >= NUM_STAGES) begin
        last_stage_d = STAGE_W'(NUM_STAGES - 1);
      end else begin
        last_stage_d = cfg_last_stage;
      end
    end
  end

  always_comb begin
    sel_pattern   = '0;
    sel_care      = '0;
    sel_edge_chan = '0;
    sel_edge_en   = 1'b0;
    sel_edge_type = 1'b0;
    sel_count     = '0;
    for (int s = 0; s < NUM_STAGES; s++) begin
      if (cur_stage_q == STAGE_W'(s)) begin
        sel_pattern   = pattern_q[stage_lo(s, SAMPLE_WIDTH) +: SAMPLE_WIDTH];
        sel_care      = care_q[stage_lo(s, SAMPLE_WIDTH) +: SAMPLE_WIDTH];
        sel_edge_chan = edge_chan_q[stage_lo(s, EDGE_CHAN_W) +: EDGE_CHAN_W];
        sel_edge_en   = edge_en_q[s];
        sel_edge_type = edge_type_q[s];
        sel_count     = count_q[stage_lo(s, COUNT_WIDTH) +: COUNT_WIDTH];
      end
    end
    // A programmed count of zero behaves as one
    sel_target = (sel_count == '0) ? COUNT_WIDTH'(1) : sel_count;
  end

  trig_stage_match #(
    .SAMPLE_WIDTH(SAMPLE_WIDTH)
  ) u_match (
    .sample      (sample_data),
    .prev_sample (prev_sample_q),
    .pattern     (sel_pattern),
    .care        (sel_care),
    .edge_chan   (sel_edge_chan),
    .edge_en     (sel_edge_en),
    .edge_type   (sel_edge_type),
    .match       (stage_match)
  );

  always_comb begin
    state_d        = state_q;
    cur_stage_d    = cur_stage_q;
    match_count_d  = match_count_q;
    prev_sample_d  = prev_sample_q;
    trig_pulse_d   = 1'b0;
    trig_latched_d = trig_latched_q;
    count_inc      = match_count_q + COUNT_WIDTH'(1);
    stage_done     = 1'b0;
`ifdef TRIG_SEQ_TIMEOUT_EN
    timeout_d      = timeout_q;
    timeout_cnt_d  = timeout_cnt_q;
    timeout_inc    = timeout_cnt_q + COUNT_WIDTH'(1);
`endif

    if (abort) begin
      state_d        = ST_IDLE;
      cur_stage_d    = '0;
      match_count_d  = '0;
      trig_latched_d = 1'b0;
`ifdef TRIG_SEQ_TIMEOUT_EN
      timeout_cnt_d  = '0;
`endif
    end else if (arm) begin
      state_d        = ST_ARMED;
      cur_stage_d    = '0;
      match_count_d  = '0;
      trig_latched_d = 1'b0;
`ifdef TRIG_SEQ_TIMEOUT_EN
      timeout_d      = cfg_timeout;
      timeout_cnt_d  = '0;
`endif
    end else if (sample_valid) begin
      case (state_q)
        ST_ARMED: begin
          // First sample only seeds the edge history
          prev_sample_d = sample_data;
          state_d       = ST_RUN;
        end
        ST_RUN: begin
          prev_sample_d = sample_data;
          if (stage_match) begin
            if (count_inc == sel_target) begin
              if (cur_stage_q == last_stage_q) begin
                match_count_d  = count_inc;
                trig_pulse_d   = 1'b1;
                trig_latched_d = 1'b1;
                state_d        = ST_DONE;
              end else begin
                cur_stage_d   = cur_stage_q + STAGE_W'(1);
                match_count_d = '0;
                stage_done    = 1'b1;
              end
            end else if (match_count_q != '1) begin
              match_count_d = count_inc;
            end
          end
`ifdef TRIG_SEQ_TIMEOUT_EN
          // A stage advance takes priority over an expiring timeout
          if (stage_done) begin
            timeout_cnt_d = '0;
          end else if ((cur_stage_q != '0) && (state_d == ST_RUN)) begin
            if ((timeout_q != '0) && (timeout_inc == timeout_q)) begin
              cur_stage_d   = '0;
              match_count_d = '0;
              timeout_cnt_d = '0;
            end else if (timeout_cnt_q != '1) begin
              timeout_cnt_d = timeout_inc;
            end
          end
`endif
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pattern_q      <= '0;
      care_q         <= '0;
      edge_chan_q    <= '0;
      edge_en_q      <= '0;
      edge_type_q    <= '0;
      count_q        <= '0;
      last_stage_q   <= '0;
      state_q        <= ST_IDLE;
      cur_stage_q    <= '0;
      match_count_q  <= '0;
      prev_sample_q  <= '0;
      trig_pulse_q   <= 1'b0;
      trig_latched_q <= 1'b0;
`ifdef TRIG_SEQ_TIMEOUT_EN
      timeout_q      <= '0;
      timeout_cnt_q  <= '0;
`endif
    end else begin
      pattern_q      <= pattern_d;
      care_q         <= care_d;
      edge_chan_q    <= edge_chan_d;
      edge_en_q      <= edge_en_d;
      edge_type_q    <= edge_type_d;
      count_q        <= count_d;
      last_stage_q   <= last_stage_d;
      state_q        <= state_d;
      cur_stage_q    <= cur_stage_d;
      match_count_q  <= match_count_d;
      prev_sample_q  <= prev_sample_d;
      trig_pulse_q   <= trig_pulse_d;
      trig_latched_q <= trig_latched_d;
`ifdef TRIG_SEQ_TIMEOUT_EN
      timeout_q      <= timeout_d;
      timeout_cnt_q  <= timeout_cnt_d;
`endif
    end
  end

  assign busy         = (state_q == ST_ARMED) || (state_q == ST_RUN);
  assign trig_pulse   = trig_pulse_q;
  assign trig_latched = trig_latched_q;
  assign cur_stage    = cur_stage_q;
  assign match_count  = match_count_q;

endmodule

// File: tb/tb_trig_seq.sv
// tb/tb_trig_seq.sv - scoreboard testbench for trig_seq
module tb_trig_seq;

  localparam int SW = 16;
  localparam int NS = 4;
  localparam int CW = 16;
  localparam int STW = $clog2(NS);

  logic                clk;
  logic                reset;
  logic                arm;
  logic                abort;
  logic                sample_valid;
  logic [SW-1:0]       sample_data;
  logic [NS*SW-1:0]    cfg_pattern;
  logic [NS*SW-1:0]    cfg_care;
  logic [NS*8-1:0]     cfg_edge_chan;
  logic [NS-1:0]       cfg_edge_en;
  logic [NS-1:0]       cfg_edge_type;
  logic [NS*CW-1:0]    cfg_count;
  logic [STW-1:0]      cfg_last_stage;
`ifdef TRIG_SEQ_TIMEOUT_EN
  logic [CW-1:0]       cfg_timeout;
`endif
  logic                busy;
  logic                trig_pulse;
  logic                trig_latched;
  logic [STW-1:0]      cur_stage;
  logic [CW-1:0]       match_count;

  trig_seq #(
    .SAMPLE_WIDTH(SW),
    .NUM_STAGES(NS),
    .COUNT_WIDTH(CW)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .arm            (arm),
    .abort          (abort),
    .sample_valid   (sample_valid),
    .sample_data    (sample_data),
    .cfg_pattern    (cfg_pattern),
    .cfg_care       (cfg_care),
    .cfg_edge_chan  (cfg_edge_chan),
    .cfg_edge_en    (cfg_edge_en),
    .cfg_edge_type  (cfg_edge_type),
    .cfg_count      (cfg_count),
    .cfg_last_stage (cfg_last_stage),
`ifdef TRIG_SEQ_TIMEOUT_EN
    .cfg_timeout    (cfg_timeout),
`endif
    .busy           (busy),
    .trig_pulse     (trig_pulse),
    .trig_latched   (trig_latched),
    .cur_stage      (cur_stage),
    .match_count    (match_count)
  );

  typedef struct {
    logic           pulse;
    logic           latched;
    logic           busy;
    logic [STW-1:0] stage;
    logic [CW-1:0]  count;
  } exp_t;

  exp_t  exp_q[$];
  int    num_checks = 0;
  int    num_errors = 0;
  int    step_no = 0;
  string test_name = "init";

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    num_checks++;
    if (act !== exp) begin
      num_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic pop_and_check();
    exp_t e;
    string t;
    t = $sformatf("%s.%0d", test_name, step_no);
    if (exp_q.size() == 0) begin
      check_eq({t, ".queue_empty"}, 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq({t, ".trig_pulse"},   32'(trig_pulse),   32'(e.pulse));
    check_eq({t, ".trig_latched"}, 32'(trig_latched), 32'(e.latched));
    check_eq({t, ".busy"},         32'(busy),         32'(e.busy));
    check_eq({t, ".cur_stage"},    32'(cur_stage),    32'(e.stage));
    check_eq({t, ".match_count"},  32'(match_count),  32'(e.count));
  endtask

  // Drive one cycle of stimulus, queue what the DUT must show after the edge
  task automatic step(input logic a_arm, input logic a_abort, input logic a_valid,
                      input logic [SW-1:0] data, input logic [STW-1:0] e_stage,
                      input logic [CW-1:0] e_count, input logic e_pulse,
                      input logic e_latched, input logic e_busy);
    exp_t e;
    arm          = a_arm;
    abort        = a_abort;
    sample_valid = a_valid;
    sample_data  = data;
    e.pulse   = e_pulse;
    e.latched = e_latched;
    e.busy    = e_busy;
    e.stage   = e_stage;
    e.count   = e_count;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    arm          = 1'b0;
    abort        = 1'b0;
    sample_valid = 1'b0;
    pop_and_check();
  endtask

  task automatic do_reset();
    exp_t e;
    reset = 1'b1;
    sample_valid = 1'b1;
    sample_data  = 16'hFFFF;
    e.pulse = 1'b0; e.latched = 1'b0; e.busy = 1'b0; e.stage = '0; e.count = '0;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    step_no++;
    reset = 1'b0;
    sample_valid = 1'b0;
    pop_and_check();
  endtask

  task automatic clear_cfg();
    cfg_pattern    = '0;
    cfg_care       = '0;
    cfg_edge_chan  = '0;
    cfg_edge_en    = '0;
    cfg_edge_type  = '0;
    cfg_count      = '0;
    cfg_last_stage = '0;
`ifdef TRIG_SEQ_TIMEOUT_EN
    cfg_timeout    = '0;
`endif
  endtask

  task automatic cfg_two_stage();
    clear_cfg();
    cfg_pattern[0*SW +: SW] = 16'h00A5;
    cfg_care[0*SW +: SW]    = 16'h00FF;
    cfg_count[0*CW +: CW]   = 16'd3;
    cfg_edge_en[1]          = 1'b1;
    cfg_edge_type[1]        = 1'b1;
    cfg_edge_chan[1*8 +: 8] = 8'd4;
    cfg_count[1*CW +: CW]   = 16'd1;
    cfg_last_stage          = 2'd1;
  endtask

  initial begin
    reset = 1'b1;
    arm = 1'b0;
    abort = 1'b0;
    sample_valid = 1'b0;
    sample_data = '0;
    clear_cfg();
    repeat (2) @(posedge clk);
    #1;

    test_name = "reset";
    do_reset();

    // 2-stage: 3 x pattern then rising edge on ch4
    test_name = "two_stage";
    cfg_two_stage();
    step(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h00A5, 0, 1, 0, 0, 1);
    step(0, 0, 1, 16'h00A5, 0, 2, 0, 0, 1);
    step(0, 0, 1, 16'h00A5, 1, 0, 0, 0, 1);
    step(0, 0, 1, 16'h00A5, 1, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0010, 1, 1, 1, 1, 0);
    step(0, 0, 0, 16'h0010, 1, 1, 0, 1, 0);
    step(0, 0, 1, 16'h0000, 1, 1, 0, 1, 0);

    // Same sequence with sample_valid gaps; arm from DONE restarts
    test_name = "gaps";
    step(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 0, 16'h00A5, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h00A5, 0, 1, 0, 0, 1);
    step(0, 0, 0, 16'h00A5, 0, 1, 0, 0, 1);
    step(0, 0, 1, 16'h00A5, 0, 2, 0, 0, 1);
    step(0, 0, 0, 16'h00A5, 0, 2, 0, 0, 1);
    step(0, 0, 1, 16'h00A5, 1, 0, 0, 0, 1);
    step(0, 0, 0, 16'h0010, 1, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0010, 1, 1, 1, 1, 0);
    step(0, 0, 0, 16'h0000, 1, 1, 0, 1, 0);

    // Edge is never seen on the first sample after arm
    test_name = "edge_first";
    clear_cfg();
    cfg_edge_en[0]   = 1'b1;
    cfg_edge_type[0] = 1'b1;
    cfg_count[0*CW +: CW] = 16'd1;
    step(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0001, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0001, 0, 1, 1, 1, 0);

    // Abort mid-run at stage 1 with two matches accumulated
    test_name = "abort";
    clear_cfg();
    cfg_count[0*CW +: CW]   = 16'd1;
    cfg_pattern[1*SW +: SW] = 16'h00FF;
    cfg_care[1*SW +: SW]    = 16'h00FF;
    cfg_count[1*CW +: CW]   = 16'd5;
    cfg_last_stage          = 2'd1;
    step(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0000, 1, 0, 0, 0, 1);
    step(0, 0, 1, 16'h00FF, 1, 1, 0, 0, 1);
    step(0, 0, 1, 16'h00FF, 1, 2, 0, 0, 1);
    step(0, 1, 1, 16'h00FF, 0, 0, 0, 0, 0);
    step(0, 0, 1, 16'h00FF, 0, 0, 0, 0, 0);
    step(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0000, 0, 0, 0, 0, 1);
    step(1, 1, 1, 16'h0000, 0, 0, 0, 0, 0);

    // Reset in the middle of a run
    test_name = "reset_mid";
    step(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0000, 1, 0, 0, 0, 1);
    step(0, 0, 1, 16'h00FF, 1, 1, 0, 0, 1);
    do_reset();

    // Config change after arm must not affect the running sequence
    test_name = "shadow";
    clear_cfg();
    cfg_pattern[0*SW +: SW] = 16'h1234;
    cfg_care[0*SW +: SW]    = 16'hFFFF;
    cfg_count[0*CW +: CW]   = 16'd1;
    step(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    cfg_pattern[0*SW +: SW] = 16'h5678;
    step(0, 0, 1, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h5678, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h1234, 0, 1, 1, 1, 0);

    // Edge channel beyond the sample width never matches
    test_name = "bad_chan";
    clear_cfg();
    cfg_edge_en[0]          = 1'b1;
    cfg_edge_type[0]        = 1'b1;
    cfg_edge_chan[0*8 +: 8] = 8'd20;
    cfg_count[0*CW +: CW]   = 16'd1;
    step(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    for (int i = 0; i < 6; i++) begin
      step(0, 0, 1, (i % 2 == 0) ? 16'h0000 : 16'hFFFF, 0, 0, 0, 0, 1);
    end
    step(0, 1, 0, 16'h0000, 0, 0, 0, 0, 0);

    // Count of zero behaves as one; all-don't-care matches every sample
    test_name = "count_zero";
    clear_cfg();
    cfg_last_stage = 2'd1;
    step(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0000, 1, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0000, 1, 1, 1, 1, 0);

`ifdef TRIG_SEQ_TIMEOUT_EN
    // Timeout returns to stage 0 but stays in RUN
    test_name = "timeout";
    clear_cfg();
    cfg_timeout             = 16'd5;
    cfg_count[0*CW +: CW]   = 16'd1;
    cfg_pattern[1*SW +: SW] = 16'hFFFF;
    cfg_care[1*SW +: SW]    = 16'hFFFF;
    cfg_count[1*CW +: CW]   = 16'd1;
    cfg_last_stage          = 2'd1;
    step(1, 0, 0, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0000, 1, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 16'h0000, 1, 0, 0, 0, 1);
    end
    step(0, 0, 1, 16'h0000, 0, 0, 0, 0, 1);
    step(0, 0, 1, 16'h0000, 1, 0, 0, 0, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/trig_seq.md
Name: trig_seq

Overview:
- Parametrised multi-stage trigger sequencer; next generation of the single pattern/edge trigger inside the logic capture peripheral.
- Sits between the synchronised sample stream and the capture controller, and replaces the one-shot trigger.
- Supports NUM_STAGES sequential conditions. Each stage has a pattern/care mask, an optional edge qualifier and an occurrence count.
- The final trigger fires only after every configured stage is satisfied in order.

Parameters:
- SAMPLE_WIDTH, 16, number of sample channels.
- NUM_STAGES, 4, number of trigger stages; must be >= 2.
- COUNT_WIDTH, 16, width of the per-stage occurrence counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle pulse; latches config and starts the sequence at stage 0.
- abort  in  1  one-cycle pulse; returns to IDLE.
- sample_valid  in  1  sample_data is valid this cycle.
- sample_data  in  SAMPLE_WIDTH  synchronised sample.
- cfg_pattern  in  NUM_STAGES*SAMPLE_WIDTH  desired values; stage i occupies slice i.
- cfg_care  in  NUM_STAGES*SAMPLE_WIDTH  1 = compare channel, 0 = don't care.
- cfg_edge_chan  in  NUM_STAGES*8  edge channel index per stage.
- cfg_edge_en  in  NUM_STAGES  edge qualifier enable per stage.
- cfg_edge_type  in  NUM_STAGES  1 = rising, 0 = falling.
- cfg_count  in  NUM_STAGES*COUNT_WIDTH  matches required per stage; 0 is treated as 1.
- cfg_last_stage  in  $clog2(NUM_STAGES)  index of the final stage used.
- busy  out  1  high in ARMED or RUN.
- trig_pulse  out  1  one-cycle pulse on final trigger.
- trig_latched  out  1  high from trigger until next arm, abort or reset.
- cur_stage  out  $clog2(NUM_STAGES)  active stage index.
- match_count  out  COUNT_WIDTH  matches accumulated in the current stage.

Behaviour:
- Reset values: state IDLE, busy 0, trig_pulse 0, trig_latched 0, cur_stage 0, match_count 0, prev_sample 0.
- States: IDLE, ARMED, RUN, DONE.
- Config is shadow-registered on arm. cfg_* changes while busy have no effect until the next arm.
- IDLE -> ARMED on arm. arm in any state restarts: stage 0, count 0, trig_latched cleared.
- ARMED: the first sample_valid loads prev_sample only; no match is evaluated. Then -> RUN.
- RUN: on each sample_valid, stage i matches when both conditions hold:
  - ((sample_data ^ pattern_i) & care_i) == 0;
  - edge_en_i is 0, or the edge condition holds: rising = prev 0 and cur 1, falling = prev 1 and cur 0, on channel edge_chan_i.
- edge_chan_i >= SAMPLE_WIDTH with edge_en_i=1: the stage never matches.
- All care bits 0 with edge_en 0: the stage matches on every valid sample.
- prev_sample updates on every sample_valid in ARMED and RUN.
- On a match, match_count increments. When the incremented value equals max(cfg_count_i, 1):
  - if i < cfg_last_stage: cur_stage <= i+1 and match_count <= 0;
  - if i == cfg_last_stage: trig_pulse=1 for one cycle, trig_latched=1, state DONE.
- Only one stage advance per sample; the sample that completes stage i is not evaluated against stage i+1.
- Latency: trig_pulse is asserted the cycle after the qualifying sample_valid cycle.
- match_count never wraps; it saturates at 2^COUNT_WIDTH-1, unreachable because the compare fires first.
- cfg_last_stage >= NUM_STAGES: clamp to NUM_STAGES-1.
- DONE: holds until arm or abort; busy=0.
- abort in any state -> IDLE; cur_stage and match_count cleared; trig_latched cleared.
- abort and arm in the same cycle: abort wins, state IDLE.
- reset asserted mid-run: all registers return to reset values on the next edge.
- sample_valid=0: no state or counter change in any state.

Optional Feature:
- Macro: TRIG_SEQ_TIMEOUT_EN.
- Defined:
  - adds input cfg_timeout [COUNT_WIDTH-1:0], latched on arm, plus an internal timeout counter of valid samples spent in stages >= 1.
  - The counter resets on every stage advance.
  - When it reaches cfg_timeout (nonzero), the sequence restarts: cur_stage 0, match_count 0; state stays RUN.
  - cfg_timeout=0 disables the timeout.
- Undefined: the port and counter are absent; a stage waits indefinitely.

Decomposition:
- Package trig_seq_pkg: state enum (IDLE, ARMED, RUN, DONE), EDGE_RISING=1, EDGE_FALLING=0, stage-slice index helper constants.
- Sub-module trig_stage_match:
  - combinational evaluator for one stage: inputs sample, prev_sample, pattern, care, edge_chan, edge_en, edge_type; output match.
  - Instantiated once, driven by a mux on cur_stage.

Test Plan:
- 2-stage sequence: stage0 pattern 0x00A5, care 0x00FF, count 3; stage1 rising edge on ch 4, care 0, count 1; cfg_last_stage=1.
  - Stimulus: drive 0x00A5 three times, then ch4 0->1.
  - Expected: cur_stage=1 after the 3rd match; trig_pulse exactly 1 cycle, one cycle after the edge sample; trig_latched=1.
- Edge never on first sample: stage0 rising on ch0, count 1; arm, first valid 0x0001.
  - Expected: no match (prev loaded). Then 0x0000, 0x0001 -> trigger.
- sample_valid gaps: same stimulus as the 2-stage test with sample_valid=0 on alternate cycles.
  - Expected: identical stage/count sequence; no change on invalid cycles.
- abort mid-run at stage 1 with match_count=2, and arm plus abort in the same cycle.
  - Expected: IDLE, cur_stage=0, match_count=0, busy=0.
- Config shadowing: change cfg_pattern after arm.
  - Expected: matching uses the armed value.
  - edge_chan=20 with SAMPLE_WIDTH=16: never triggers.
- With TRIG_SEQ_TIMEOUT_EN, cfg_timeout=5: stage0 satisfied, then 5 non-matching valid samples.
  - Expected: cur_stage returns to 0, state RUN, no trig_pulse.
